// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad encoder: key count, code width,
// idle code, FSM state encoding and lowest-set-index priority search.
package keypad_pkg;

  localparam int unsigned NUM_KEYS = 32;
  localparam int unsigned CODE_W   = 5;

  localparam logic [CODE_W-1:0] CODE_IDLE = 5'b11111;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DEBOUNCE = 3'd1,
    VALID    = 3'd2,
    HOLD     = 3'd3,
    RELEASE  = 3'd4
  } kp_state_t;

  // Lowest set bit wins; returns 0 for an all-zero vector.
  function automatic logic [4:0] lowest_index(input logic [31:0] vec);
    logic [4:0] idx;
    idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (vec[i]) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/key_sync.sv
// Two-flop synchronizer bringing asynchronous key lines into the clk domain.
module key_sync #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_encoder.sv
// Debounced one-shot keypad encoder: 32 raw key lines to active-low key code
// over valid/ready. Define KEYPAD_AUTO_REPEAT_EN to enable auto-repeat.
module keypad_encoder
  import keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned REPEAT_CYCLES   = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] keys_in,
  input  logic                key_ready,
  output logic                key_valid,
  output logic [CODE_W-1:0]   code_n,
  output logic                multi_key
);

  localparam int unsigned CNT_MAX = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES
                                                                       : REPEAT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [2:0] ST_IDLE     = IDLE;
  localparam logic [2:0] ST_DEBOUNCE = DEBOUNCE;
  localparam logic [2:0] ST_VALID    = VALID;
  localparam logic [2:0] ST_RELEASE  = RELEASE;
`ifdef KEYPAD_AUTO_REPEAT_EN
  localparam logic [2:0]       ST_HOLD  = HOLD;
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

  logic [NUM_KEYS-1:0] keys_s;
  logic [2:0]          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CODE_W-1:0]   idx_q, idx_d;
  logic                multi_q, multi_d;
  logic                valid_d, mk_d;
  logic [CODE_W-1:0]   code_d;
  logic                key_held;

  key_sync #(.WIDTH(NUM_KEYS)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (keys_in),
    .q   (keys_s)
  );

  assign key_held = keys_s[idx_q];

  // Next-state and registered-output logic; every state change clears the counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    multi_d = multi_q;
    valid_d = key_valid;
    code_d  = code_n;
    mk_d    = multi_key;

    case (state_q)
      ST_IDLE: begin
        if (|keys_s) begin
          state_d = ST_DEBOUNCE;
          idx_d   = lowest_index(keys_s);
          multi_d = ($countones(keys_s) > 1);
          cnt_d   = '0;
        end
      end

      ST_DEBOUNCE: begin
        if (!key_held) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = ST_VALID;
          cnt_d   = '0;
          valid_d = 1'b1;
          code_d  = ~idx_q;
          mk_d    = multi_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // Event is held until accepted; a key release here never retracts it.
      ST_VALID: begin
        if (key_ready) begin
          valid_d = 1'b0;
          cnt_d   = '0;
`ifdef KEYPAD_AUTO_REPEAT_EN
          state_d = ST_HOLD;
`else
          state_d = ST_RELEASE;
`endif
        end
      end

`ifdef KEYPAD_AUTO_REPEAT_EN
      ST_HOLD: begin
        if (!key_held) begin
          state_d = ST_RELEASE;
          cnt_d   = '0;
        end else if (cnt_q == REP_LAST) begin
          state_d = ST_VALID;
          cnt_d   = '0;
          valid_d = 1'b1;
          mk_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif

      ST_RELEASE: begin
        if (key_held) begin
          cnt_d = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      multi_q   <= 1'b0;
      key_valid <= 1'b0;
      code_n    <= CODE_IDLE;
      multi_key <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      multi_q   <= multi_d;
      key_valid <= valid_d;
      code_n    <= code_d;
      multi_key <= mk_d;
    end
  end

endmodule

// File: tb/tb_keypad_encoder.sv
// Randomized self-checking bench for keypad_encoder; expected event timing and
// codes are derived arithmetically from the key waveform each scenario applies.
module tb_keypad_encoder;

  localparam int unsigned D = 4;
  localparam int unsigned R = 8;
`ifdef KEYPAD_AUTO_REPEAT_EN
  localparam int unsigned X = 1;
`else
  localparam int unsigned X = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] keys_in;
  logic        key_ready;
  logic        key_valid;
  logic [4:0]  code_n;
  logic        multi_key;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  keypad_encoder #(.DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(R)) dut (
    .clk       (clk),
    .rst       (rst),
    .keys_in   (keys_in),
    .key_ready (key_ready),
    .key_valid (key_valid),
    .code_n    (code_n),
    .multi_key (multi_key)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Active-low code of the lowest pressed key: 31 - index.
  function automatic logic [4:0] exp_code(input logic [31:0] k);
    for (int i = 0; i < 32; i++) if (k[i]) return 5'(31 - i);
    return 5'b11111;
  endfunction

  function automatic logic [31:0] rand_keys(input bit multi);
    int idx;
    logic [31:0] k;
    idx = $urandom_range(31);
    k = 32'h1 << idx;
    if (multi) k = k | ($urandom() & ~((32'h2 << idx) - 32'h1));
    return k;
  endfunction

  task automatic test_reset();
    rst = 1'b1; keys_in = '0; key_ready = 1'b0;
    for (int c = 0; c < 3; c++) step();
    n_checks++;
    if (key_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", key_valid); end
    n_checks++;
    if (code_n !== 5'b11111) begin n_fail++; $display("FAIL reset_code got=%b exp=11111", code_n); end
    n_checks++;
    if (multi_key !== 1'b0) begin n_fail++; $display("FAIL reset_multi got=%b exp=0", multi_key); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_clean_press();
    logic [31:0] k;
    logic [4:0]  ec;
    logic        em;
    int          d, h;
    bit          rel;
    for (int it = 0; it < 8; it++) begin
      if (it == 0)      k = 32'h1 << 9;
      else if (it == 1) k = (32'h1 << 5) | (32'h1 << 20);
      else              k = rand_keys(it % 2 == 1);
      ec = exp_code(k);
      em = ($countones(k) > 1);
      key_ready = 1'b0;
      keys_in = k;
      for (int n = 1; n <= int'(D) + 3; n++) begin
        step();
        n_checks++;
        if (key_valid !== (n == int'(D) + 3)) begin
          n_fail++;
          $display("FAIL press_latency it=%0d edge=%0d got=%b exp=%b", it, n, key_valid, (n == int'(D) + 3));
        end
      end
      n_checks++;
      if (code_n !== ec || multi_key !== em) begin
        n_fail++;
        $display("FAIL press_code it=%0d code_n=%b multi=%b exp code_n=%b multi=%b", it, code_n, multi_key, ec, em);
      end
      d = $urandom_range(10, 0);
      rel = 1'($urandom_range(1, 0));
      if (rel) keys_in = '0;
      for (int c = 0; c < d; c++) begin
        step();
        n_checks++;
        if (key_valid !== 1'b1 || code_n !== ec || multi_key !== em) begin
          n_fail++;
          $display("FAIL backpressure it=%0d valid=%b code_n=%b multi=%b exp 1/%b/%b", it, key_valid, code_n, multi_key, ec, em);
        end
      end
      key_ready = 1'b1;
      step();
      n_checks++;
      if (key_valid !== 1'b0) begin n_fail++; $display("FAIL handshake_drop it=%0d got=%b exp=0", it, key_valid); end
`ifdef KEYPAD_AUTO_REPEAT_EN
      h = rel ? 0 : 4;
`else
      h = rel ? 0 : int'($urandom_range(30, 5));
`endif
      for (int c = 0; c < h; c++) begin
        step();
        n_checks++;
        if (key_valid !== 1'b0) begin n_fail++; $display("FAIL no_repeat it=%0d cyc=%0d got=%b exp=0", it, c, key_valid); end
      end
      keys_in = '0;
      for (int c = 0; c < int'(D) + 6; c++) begin
        step();
        n_checks++;
        if (key_valid !== 1'b0) begin n_fail++; $display("FAIL release_quiet it=%0d cyc=%0d got=%b exp=0", it, c, key_valid); end
      end
      key_ready = 1'b0;
    end
  endtask

  task automatic test_bounce();
    int runs[$];
    logic [31:0] k;
    key_ready = 1'b1;
    for (int it = 0; it < 5; it++) begin
      runs.delete();
      if (it == 0) begin
        k = 32'h1 << 3;
        runs.push_back(2); runs.push_back(1); runs.push_back(2);
      end else begin
        k = rand_keys(1'b0);
        for (int r = 0; r < int'($urandom_range(7, 3)); r++)
          runs.push_back((r % 2 == 0) ? int'($urandom_range(D, 1)) : int'($urandom_range(3, 1)));
      end
      foreach (runs[r]) begin
        keys_in = (r % 2 == 0) ? k : 32'h0;
        for (int c = 0; c < runs[r]; c++) begin
          step();
          n_checks++;
          if (key_valid !== 1'b0) begin n_fail++; $display("FAIL bounce it=%0d run=%0d got=%b exp=0", it, r, key_valid); end
        end
      end
      keys_in = '0;
      for (int c = 0; c < int'(D) + 6; c++) begin
        step();
        n_checks++;
        if (key_valid !== 1'b0) begin n_fail++; $display("FAIL bounce_tail it=%0d got=%b exp=0", it, key_valid); end
      end
    end
    key_ready = 1'b0;
  endtask

  // A high pulse of D+1 cycles is the shortest one accepted.
  task automatic test_glitch_boundary();
    logic [31:0] k;
    logic        ev;
    key_ready = 1'b1;
    for (int len = int'(D); len <= int'(D) + 1; len++) begin
      k = rand_keys(1'b0);
      keys_in = k;
      for (int n = 1; n <= int'(D) + 12; n++) begin
        step();
        if (n == len) keys_in = '0;
        ev = (len >= int'(D) + 1) && (n == int'(D) + 3);
        n_checks++;
        if (key_valid !== ev) begin n_fail++; $display("FAIL glitch len=%0d edge=%0d got=%b exp=%b", len, n, key_valid, ev); end
        if (ev) begin
          n_checks++;
          if (code_n !== exp_code(k)) begin n_fail++; $display("FAIL glitch_code got=%b exp=%b", code_n, exp_code(k)); end
        end
      end
    end
    key_ready = 1'b0;
  endtask

  // Re-press after a low gap: accepted only once the release has fully debounced.
  task automatic test_release_gap();
    int          gaps[3];
    logic [31:0] k;
    int          g, exp_edge;
    logic        ev, ok;
    gaps[0] = int'(D + X) - 1;
    gaps[1] = int'(D + X);
    gaps[2] = int'(D + X) + int'($urandom_range(3, 1));
    key_ready = 1'b1;
    for (int it = 0; it < 3; it++) begin
      g = gaps[it];
      k = rand_keys(1'b0);
      keys_in = k;
      for (int n = 1; n <= int'(D) + 3; n++) step();
      n_checks++;
      if (key_valid !== 1'b1) begin n_fail++; $display("FAIL gap_first_event g=%0d got=%b exp=1", g, key_valid); end
      for (int c = 0; c < 3; c++) step();
      keys_in = '0;
      for (int n = 1; n <= g; n++) begin
        step();
        n_checks++;
        if (key_valid !== 1'b0) begin n_fail++; $display("FAIL gap_low g=%0d edge=%0d got=%b exp=0", g, n, key_valid); end
      end
      keys_in = k;
      ok = (g >= int'(D + X));
      exp_edge = g + int'(D) + 3;
      for (int n = g + 1; n <= g + int'(D) + 6; n++) begin
        step();
        ev = ok && (n == exp_edge);
        n_checks++;
        if (key_valid !== ev) begin n_fail++; $display("FAIL gap_repress g=%0d edge=%0d got=%b exp=%b", g, n, key_valid, ev); end
      end
      keys_in = '0;
      for (int c = 0; c < int'(D) + 8; c++) begin
        step();
        n_checks++;
        if (key_valid !== 1'b0) begin n_fail++; $display("FAIL gap_tail g=%0d got=%b exp=0", g, key_valid); end
      end
    end
    key_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] k;
    logic        ev;
    for (int it = 0; it < 3; it++) begin
      k = rand_keys(it == 1);
      key_ready = 1'b0;
      keys_in = k;
      for (int n = 1; n <= int'(D) + 3; n++) step();
      for (int c = 0; c < int'($urandom_range(3, 0)); c++) step();
      n_checks++;
      if (key_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre it=%0d got=%b exp=1", it, key_valid); end
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_checks++;
      if (key_valid !== 1'b0 || code_n !== 5'b11111 || multi_key !== 1'b0) begin
        n_fail++;
        $display("FAIL rstmid_clear it=%0d valid=%b code_n=%b multi=%b exp 0/11111/0", it, key_valid, code_n, multi_key);
      end
      for (int n = 1; n <= int'(D) + 3; n++) begin
        step();
        ev = (n == int'(D) + 3);
        n_checks++;
        if (key_valid !== ev) begin n_fail++; $display("FAIL rstmid_fresh it=%0d edge=%0d got=%b exp=%b", it, n, key_valid, ev); end
      end
      n_checks++;
      if (code_n !== exp_code(k) || multi_key !== ($countones(k) > 1)) begin
        n_fail++;
        $display("FAIL rstmid_code it=%0d code_n=%b multi=%b exp %b/%b", it, code_n, multi_key, exp_code(k), ($countones(k) > 1));
      end
      key_ready = 1'b1;
      step();
      n_checks++;
      if (key_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_drop it=%0d got=%b exp=0", it, key_valid); end
      keys_in = '0;
      for (int c = 0; c < int'(D) + 8; c++) step();
    end
    key_ready = 1'b0;
  endtask

`ifdef KEYPAD_AUTO_REPEAT_EN
  task automatic test_auto_repeat();
    logic [31:0] k;
    int          hold, first;
    logic        ev;
    first = int'(D) + 3;
    key_ready = 1'b1;
    for (int it = 0; it < 2; it++) begin
      k = (it == 0) ? (32'h1 << 31) : ((32'h1 << 7) | (32'h1 << 12));
      hold = (it == 0) ? 40 : 30;
      keys_in = k;
      for (int n = 1; n <= hold + int'(D) + 8; n++) begin
        step();
        if (n == hold) keys_in = '0;
        ev = (n >= first) && ((n - first) % int'(R + 1) == 0) && (n <= hold + 2);
        n_checks++;
        if (key_valid !== ev) begin n_fail++; $display("FAIL repeat it=%0d edge=%0d got=%b exp=%b", it, n, key_valid, ev); end
        if (ev) begin
          n_checks++;
          if (code_n !== exp_code(k) || multi_key !== ((n == first) && ($countones(k) > 1))) begin
            n_fail++;
            $display("FAIL repeat_code it=%0d edge=%0d code_n=%b multi=%b exp %b/%b", it, n, code_n, multi_key,
                     exp_code(k), ((n == first) && ($countones(k) > 1)));
          end
        end
      end
    end
    key_ready = 1'b0;
  endtask
`else
  task automatic test_single_event();
    logic [31:0] k;
    int          events, first_edge;
    for (int it = 0; it < 2; it++) begin
      k = rand_keys(it == 1);
      key_ready = 1'b1;
      keys_in = k;
      events = 0;
      first_edge = -1;
      for (int n = 1; n <= 60; n++) begin
        step();
        if (key_valid === 1'b1) begin
          events++;
          if (first_edge < 0) first_edge = n;
        end
      end
      n_checks++;
      if (events != 1 || first_edge != int'(D) + 3) begin
        n_fail++;
        $display("FAIL single_event it=%0d events=%0d first=%0d exp events=1 first=%0d", it, events, first_edge, D + 3);
      end
      keys_in = '0;
      for (int c = 0; c < int'(D) + 6; c++) step();
    end
    key_ready = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1;
    keys_in = '0;
    key_ready = 1'b0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch_boundary();
    test_release_gap();
    test_reset_mid();
`ifdef KEYPAD_AUTO_REPEAT_EN
    test_auto_repeat();
`else
    test_single_event();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
